// File: rtl/mmio_uart_defs.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serializer state encodings.
package mmio_uart_defs;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_EMPTY  = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_PARITY = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path. A push while full is accepted
// only when a pop happens on the same edge; count ranges 0..DEPTH.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define validity, and leaving it out keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus register decode, TX FIFO, baud/bit
// counters and serializer FSM. Define UART_TX_PARITY_EN for 8E1 frames.
module mmio_uart_tx
  import mmio_uart_defs::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        dm_ena,
  input  logic        dm_wena,
  input  logic [10:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        uart_txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  tx_state_e   state_q, state_d;
  logic [15:0] baud_div, div_lat, baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        parity_q, ovf;
  logic        wr_en, push_req, pop, start_frame, bit_done;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{dm_addr[10:2], dm_wdata[31:16]};
  assign wr_en    = sel & dm_ena & dm_wena;
  assign push_req = wr_en & (dm_addr[1:0] == REG_TXDATA);
  assign bit_done = (baud_cnt == '0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (dm_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_div <= 16'(DEFAULT_DIV);
      ovf      <= 1'b0;
    end else begin
      if (wr_en && dm_addr[1:0] == REG_BAUDDIV) baud_div <= dm_wdata[15:0];
      // A dropped push (full, no simultaneous pop) wins over nothing; clears come via STATUS.
      if (push_req && fifo_full && !pop) ovf <= 1'b1;
      else if (wr_en && dm_addr[1:0] == REG_STATUS && dm_wdata[STAT_OVF]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop         = 1'b1;
        start_frame = 1'b1;
        state_d     = S_START;
      end
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA: if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        state_d = S_PARITY;
`else
        state_d = S_STOP;
`endif
      end
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP: if (bit_done) begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          start_frame = 1'b1;
          state_d     = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The divisor is latched at frame start so mid-frame BAUDDIV writes only affect the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_lat  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else if (start_frame) begin
      div_lat  <= baud_div;
      baud_cnt <= baud_div;
      bit_cnt  <= '0;
      shift_q  <= fifo_dout;
      parity_q <= ^fifo_dout;
    end else if (state_q != S_IDLE) begin
      if (bit_done) begin
        baud_cnt <= div_lat;
        if (state_q == S_DATA) begin
          shift_q <= shift_q >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  always_comb begin
    uart_txd = 1'b1;
    case (state_q)
      S_START:  uart_txd = 1'b0;
      S_DATA:   uart_txd = shift_q[0];
      S_PARITY: uart_txd = parity_q;
      default:  uart_txd = 1'b1;
    endcase
  end

  always_comb begin
    status                = '0;
    status[STAT_BUSY]     = (state_q != S_IDLE);
    status[STAT_FULL]     = fifo_full;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_OVF]      = ovf;
    status[STAT_PARITY]   = PARITY_EN;
    status[15:8]          = 8'(fifo_count);
  end

  always_comb begin
    dm_rdata = '0;
    if (sel && dm_ena && !dm_wena) begin
      case (dm_addr[1:0])
        REG_STATUS:  dm_rdata = status;
        REG_BAUDDIV: dm_rdata = {16'h0000, baud_div};
        default:     dm_rdata = '0;
      endcase
    end
  end

endmodule
